div_8bit_seq: RTL and testbench

Sequential 8-bit unsigned restoring divider. It sits directly downstream of the 8-bit carry-look-ahead adder/subtractor and instantiates one clas_8bit, tied to subtract mode (sel=1), for the trial subtraction on every iteration. It produces one quotient bit per clock under a start/busy/done handshake. It is the divide unit for the arithmetic block set.

---
 rtl/div_8bit_seq_if.sv | 32 +++
 rtl/div_8bit_seq.sv | 209 ++++++++++++++++++++
 tb/tb_div_8bit_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_8bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_8bit_seq_if
// Description : Start/busy/done handshake and operand/result bus for the
//               8-bit sequential divider.
//               master : drives start, dividend, divisor; observes results
//               slave  : the divider; observes request, drives results
//               Signals: start, dividend[7:0], divisor[7:0], quotient[7:0],
//                        remainder[7:0], busy, done, dz
// Revision    : 1.0 - initial release
// ============================================================================
interface div_8bit_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dz
    );
endinterface
`default_nettype wire

// File: rtl/div_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : clas_8bit
// Description : 8-bit carry-look-ahead adder/subtractor.
//               sel=0 : sum = a + b
//               sel=1 : sum = a - b  (c_out=1 means no borrow, i.e. a >= b)
//               Ports : a[7:0], b[7:0], sel in; sum[7:0], c_out out
// Revision    : 1.0 - initial release
// ============================================================================
module clas_8bit (
    input  wire logic [7:0] a,
    input  wire logic [7:0] b,
    input  wire logic       sel,
    output logic      [7:0] sum,
    output logic            c_out
);
    logic [7:0] w_b;
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    // Subtraction is a + ~b + 1; sel doubles as the carry-in.
    assign w_b = b ^ {8{sel}};
    assign w_g = a & w_b;
    assign w_p = a ^ w_b;

    // Each carry is expanded into its full sum-of-products form, so no carry
    // depends on a lower carry signal.
    always_comb begin
        logic w_term;
        logic w_acc;
        w_term = 1'b0;
        w_acc  = 1'b0;
        w_c    = '0;
        w_c[0] = sel;
        for (int i = 0; i < 8; i++) begin
            w_term = w_p[i];
            w_acc  = w_g[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc  = w_acc | (w_term & w_g[j]);
                w_term = w_term & w_p[j];
            end
            w_c[i+1] = w_acc | (w_term & sel);
        end
    end

    assign sum   = w_p ^ w_c[7:0];
    assign c_out = w_c[8];
endmodule

// ============================================================================
// Module      : div_8bit_seq
// Description : Sequential 8-bit unsigned restoring divider, one quotient bit
//               per clock, start/busy/done handshake.
//               Ports : clk, rst (sync, active-high)
//                       bus (div_8bit_seq_if.slave): start, dividend, divisor
//                       in; quotient, remainder, busy, done, dz out
//               DZ_QUOT : quotient reported on divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
module div_8bit_seq #(
    parameter logic [7:0] DZ_QUOT = 8'hFF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    div_8bit_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_d;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic [2:0] r_cnt;
    logic [7:0] r_quotient;
    logic [7:0] r_remainder;
    logic       r_dz;

    logic       w_busy;
    logic       w_done;
    logic [8:0] w_r9;
    logic [7:0] w_diff;
    logic       w_c_out;
    logic       w_ge;
    logic [7:0] w_r_next;
    logic [7:0] w_q_next;
    logic       w_last;

    // ------------------------------------------------------------------
    // Iteration datapath: shift the next dividend bit into the partial
    // remainder and trial-subtract the divisor.
    // ------------------------------------------------------------------
    assign w_r9 = {r_r, r_q[7]};

    clas_8bit u_clas (
        .a     (w_r9[7:0]),
        .b     (r_d),
        .sel   (1'b1),
        .sum   (w_diff),
        .c_out (w_c_out)
    );

    // A set bit 8 means the shifted remainder is >= 256 > D, so the
    // subtraction fits even though the 8-bit subtractor reports a borrow;
    // its low 8 bits are still the correct difference.
    assign w_ge     = w_r9[8] | w_c_out;
    assign w_r_next = w_ge ? w_diff : w_r9[7:0];
    assign w_q_next = {r_q[6:0], w_ge};
    assign w_last   = (r_cnt == 3'd7);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.divisor == 8'd0) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, working and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != 8'd0) begin
                            r_d   <= bus.divisor;
                            r_q   <= bus.dividend;
                            r_r   <= '0;
                            r_cnt <= '0;
                        end else begin
                            // Divide-by-zero skips the iterations and
                            // publishes its result straight away.
                            r_quotient  <= DZ_QUOT;
                            r_remainder <= bus.dividend;
                            r_dz        <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        // dz is cleared together with the new results so the
                        // previous result set stays intact until this edge.
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next;
                        r_dz        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.dz        = r_dz;
endmodule
`default_nettype wire

// File: tb/tb_div_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_8bit_seq
// Description : Self-checking bench for div_8bit_seq. A monitor pushes the
//               expected result of every accepted request to a scoreboard
//               queue and pops/compares it on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_8bit_seq;
    logic clk;
    logic rst;

    div_8bit_seq_if bus ();

    div_8bit_seq #(.DZ_QUOT(8'hFF)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    logic in_sweep = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on request acceptance, pop on done.
    always @(negedge clk) begin
        exp_t e;
        string tag;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    tag = $sformatf("%s%0d/%0d", in_sweep ? "sweep " : "", e.a, e.b);
                    check({tag, " quotient"},  bus.quotient,  e.q);
                    check({tag, " remainder"}, bus.remainder, e.r);
                    check({tag, " dz"},        bus.dz,        e.dz);
                    check({tag, " latency"},   cyc - e.t0,    e.dz ? 1 : 9);
                    check({tag, " busy_len"},  busy_cnt,      e.dz ? 1 : 9);
                end
            end
            // busy low means IDLE, so start is taken at the next edge.
            if (bus.start && !bus.busy) begin
                e.a  = bus.dividend;
                e.b  = bus.divisor;
                e.dz = (bus.divisor == 8'd0);
                e.q  = e.dz ? 8'hFF : 8'(bus.dividend / bus.divisor);
                e.r  = e.dz ? bus.dividend : 8'(bus.dividend % bus.divisor);
                e.t0 = cyc;
                sb.push_back(e);
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("idle_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " quotient"},  bus.quotient,  0);
        check({tag, " remainder"}, bus.remainder, 0);
        check({tag, " busy"},      bus.busy,      0);
        check({tag, " done"},      bus.done,      0);
        check({tag, " dz"},        bus.dz,        0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        int err_before;
        logic ok;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic divides and boundaries
        do_div(8'd200, 8'd7);
        do_div(8'd255, 8'd1);
        do_div(8'd5,   8'd9);
        do_div(8'd255, 8'd16);
        do_div(8'd128, 8'd128);

        // Divide-by-zero followed by a normal divide
        do_div(8'd173, 8'd0);
        do_div(8'd10,  8'd3);

        // start while busy is ignored
        done_before = n_done;
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignored_start done_count", n_done - done_before, 1);

        // Reset in the middle of a divide
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'd240;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        done_before = n_done;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("abort");
        repeat (12) @(negedge clk);
        check("abort done_count", n_done - done_before, 0);
        do_div(8'd240, 8'd7);

        // Sweep with start held high: all divisors against a spread of
        // dividends including 0 and 255.
        in_sweep  = 1'b1;
        ok        = 1'b1;
        err_before = n_errors;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        for (int a = 0; a < 256 && ok; a += 17) begin
            for (int b = 0; b < 256 && ok; b++) begin
                logic seen;
                bus.dividend = 8'(a);
                bus.divisor  = 8'(b);
                seen = 1'b0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (!bus.busy) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) begin
                    check($sformatf("sweep %0d/%0d accept_timeout", a, b), 0, 1);
                    ok = 1'b0;
                end
                @(posedge clk);
                #1;
                if (n_errors != err_before) ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        wait_idle();
        in_sweep = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
